// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// segment ROM, blank code, digit enable patterns and the scan state enum.
package display_pkg;

    // All segments off (active-low drive)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g patterns for BCD digits 0..9, seg[6]=a ... seg[0]=g
    localparam logic [0:9][6:0] SEG_ROM = {
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Active-low digit enables: bit2=centena, bit1=decena, bit0=unidad
    localparam logic [2:0] EN_CEN = 3'b011;
    localparam logic [2:0] EN_DEC = 3'b101;
    localparam logic [2:0] EN_UNI = 3'b110;
    localparam logic [2:0] EN_OFF = 3'b111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Enable pattern for a digit index (0=centena, 1=decena, 2=unidad)
    function automatic logic [2:0] digit_enable(input logic [1:0] idx);
        case (idx)
            2'd0:    return EN_CEN;
            2'd1:    return EN_DEC;
            2'd2:    return EN_UNI;
            default: return EN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low seven-segment decode; codes 10..15 blank.
module bcd_seg_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Look up the ROM for valid digits, blank everything else
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_ROM[bcd];
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Three-digit common-anode display scanner: per-digit slot of DIV cycles,
// BLANK_CYCLES of dead time followed by SHOW_CYCLES of digit drive.
// The three digits are captured once per frame so a frame is never torn.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] centena,
    input  logic [3:0] decena,
    input  logic [3:0] unidad,
    output logic [6:0] seg,
    output logic [2:0] SevenSegmentEnable,
    output logic       dot
);

    localparam int DIV         = CLK_HZ / SCAN_HZ;
    localparam int SHOW_CYCLES = DIV - BLANK_CYCLES;
    localparam int CNT_W       = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;
    logic [11:0]      capture, capture_next;
    logic [3:0]       show_digit;
    logic [6:0]       decoded;
    logic             digit_blanked;
    logic [6:0]       seg_next;
    logic [2:0]       en_next;

    assign dot = 1'b1;

    // Slot sequencing: count through BLANK then SHOW, advancing the digit after SHOW
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        idx_next   = idx;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
                idx_next   = 2'd0;
            end
        endcase
    end

    // Track inputs only during the centena dead time so the frame stays consistent
    always_comb begin
        capture_next = capture;
        if (state == BLANK && idx == 2'd0) begin
            capture_next = {centena, decena, unidad};
        end
    end

    // Select the digit that will be shown after the coming edge
    always_comb begin
        case (idx_next)
            2'd0:    show_digit = capture_next[11:8];
            2'd1:    show_digit = capture_next[7:4];
            default: show_digit = capture_next[3:0];
        endcase
    end

    bcd_seg_decode u_decode (
        .bcd (show_digit),
        .seg (decoded)
    );

    // Decide whether the upcoming digit is suppressed as a leading zero
    always_comb begin
`ifdef DISPLAY_SCAN_LZB_EN
        digit_blanked = ((idx_next == 2'd0) && (capture_next[11:8] == 4'd0)) ||
                        ((idx_next == 2'd1) && (capture_next[11:4] == 8'd0));
`else
        digit_blanked = 1'b0;
`endif
    end

    // Output values that accompany the next state, so they switch on the same edge
    always_comb begin
        seg_next = SEG_BLANK;
        en_next  = EN_OFF;
        if (state_next == SHOW && !digit_blanked) begin
            seg_next = decoded;
            en_next  = digit_enable(idx_next);
        end
    end

    // State, counters, capture and registered display outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= BLANK;
            cnt                <= '0;
            idx                <= 2'd0;
            capture            <= '0;
            seg                <= SEG_BLANK;
            SevenSegmentEnable <= EN_OFF;
        end else begin
            state              <= state_next;
            cnt                <= cnt_next;
            idx                <= idx_next;
            capture            <= capture_next;
            seg                <= seg_next;
            SevenSegmentEnable <= en_next;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DIV=10, BLANK_CYCLES=2.
// The reference model works from the elapsed cycle count since reset:
// slot = count/10 mod 3, position in slot = count mod 10.
module tb_display_scan_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] centena;
    logic [3:0] decena;
    logic [3:0] unidad;
    logic [6:0] seg;
    logic [2:0] SevenSegmentEnable;
    logic       dot;

    int tests_run = 0;
    int failed    = 0;

    // Model state: edges since reset release and digits latched for current frame
    int p = 0;
    int cap_c = 0;
    int cap_d = 0;
    int cap_u = 0;

    logic [6:0] seg_table [10];

    display_scan_ctrl #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .centena            (centena),
        .decena             (decena),
        .unidad             (unidad),
        .seg                (seg),
        .SevenSegmentEnable (SevenSegmentEnable),
        .dot                (dot)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rst, input logic [3:0] c,
                                 input logic [3:0] d, input logic [3:0] u);
        reset   = rst;
        centena = c;
        decena  = d;
        unidad  = u;
        if (rst) begin
            p     = 0;
            cap_c = 0;
            cap_d = 0;
            cap_u = 0;
        end else begin
            if (p % 30 == 1) begin
                cap_c = int'(c);
                cap_d = int'(d);
                cap_u = int'(u);
            end
            p = p + 1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag);
        int         pos;
        int         slot;
        int         digit;
        bit         lzb;
        logic [6:0] exp_seg;
        logic [2:0] exp_en;
        pos     = p % 10;
        slot    = (p / 10) % 3;
        exp_seg = 7'h7F;
        exp_en  = 3'b111;
        lzb     = 1'b0;
        digit   = (slot == 0) ? cap_c : (slot == 1) ? cap_d : cap_u;
`ifdef DISPLAY_SCAN_LZB_EN
        if (slot == 0 && cap_c == 0) lzb = 1'b1;
        if (slot == 1 && cap_c == 0 && cap_d == 0) lzb = 1'b1;
`endif
        if (pos >= 2 && !lzb) begin
            exp_en  = (slot == 0) ? 3'b011 : (slot == 1) ? 3'b101 : 3'b110;
            exp_seg = (digit <= 9) ? seg_table[digit] : 7'h7F;
        end
        tests_run++;
        assert (seg === exp_seg) else begin
            failed++;
            $error("[TB] FAIL %s seg p=%0d: got %b expected %b", tag, p, seg, exp_seg);
        end
        tests_run++;
        assert (SevenSegmentEnable === exp_en) else begin
            failed++;
            $error("[TB] FAIL %s enable p=%0d: got %b expected %b", tag, p, SevenSegmentEnable, exp_en);
        end
        tests_run++;
        assert (dot === 1'b1) else begin
            failed++;
            $error("[TB] FAIL %s dot p=%0d: got %b expected 1", tag, p, dot);
        end
    endtask

    task automatic runCycle(input logic rst, input logic [3:0] c, input logic [3:0] d,
                            input logic [3:0] u, input string tag);
        applyStimulus(rst, c, d, u);
        checkOutput(tag);
    endtask

    initial begin
        logic [3:0] rc, rd, ru;
        seg_table = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        reset   = 1'b1;
        centena = 4'd0;
        decena  = 4'd3;
        unidad  = 4'd2;

        // Reset held three cycles, then two full frames of 0/3/2
        repeat (3) runCycle(1'b1, 4'd0, 4'd3, 4'd2, "reset");
        repeat (60) runCycle(1'b0, 4'd0, 4'd3, 4'd2, "scan032");

        // Change inputs inside the decena slot; current frame must not tear
        for (int i = 0; i < 30 && (p % 30) != 13; i++)
            runCycle(1'b0, 4'd0, 4'd3, 4'd2, "scan032");
        repeat (50) runCycle(1'b0, 4'd0, 4'd1, 4'd5, "frame015");

        // Out-of-range units digit
        repeat (40) runCycle(1'b0, 4'd1, 4'd2, 4'hC, "badunit");

        // Reset in the middle of the decena SHOW (4th cycle of the slot's SHOW)
        for (int i = 0; i < 30 && (p % 30) != 16; i++)
            runCycle(1'b0, 4'd4, 4'd5, 4'd6, "premid");
        runCycle(1'b1, 4'd4, 4'd5, 4'd6, "midreset");
        repeat (35) runCycle(1'b0, 4'd4, 4'd5, 4'd6, "restart");

        // Leading zeros: blanked with LZB, shown as zero without it
        repeat (65) runCycle(1'b0, 4'd0, 4'd0, 4'd7, "lead007");

        // Randomized inputs with occasional changes and rare resets
        rc = 4'd9; rd = 4'd8; ru = 4'd7;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) rc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ru = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) rc = 4'd0;
            runCycle(($urandom_range(0, 99) == 0), rc, rd, ru, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the three-digit common-anode seven-segment display on the frequency-selector board. It takes the centena/decena/unidad BCD digits from the frequency mux and decodes them internally. It then drives one digit at a time with a fixed per-digit slot and a dead-time blank between digits to suppress ghosting. It replaces ad-hoc select-counter scanning with a single-clock, reset-defined FSM and frame-consistent digit capture.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- SCAN_HZ, 500, digit slot rate in Hz; slot period DIV = CLK_HZ/SCAN_HZ cycles
- BLANK_CYCLES, 64, dead-time cycles per slot; legal range 1 ≤ BLANK_CYCLES < DIV

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- centena  in  4  hundreds BCD digit
- decena  in  4  tens BCD digit
- unidad  in  4  units BCD digit
- seg  out  7  segment drive, active-low, seg[6]=a … seg[0]=g
- SevenSegmentEnable  out  3  digit enable, active-low; bit2=centena, bit1=decena, bit0=unidad
- dot  out  1  decimal point, active-low; constant 1 (off)

## Operation
- The FSM has two states, BLANK and SHOW, plus a digit index idx in 0..2: 0=centena, 1=decena, 2=unidad.
- Each state has a cycle counter cnt that clears on every state change.
- BLANK behaviour:
  - SevenSegmentEnable=3'b111 and seg=7'h7F.
  - When cnt==BLANK_CYCLES-1, the next edge goes to SHOW with cnt=0.
- SHOW behaviour:
  - SevenSegmentEnable is 3'b011, 3'b101 or 3'b110 for idx 0, 1 or 2.
  - seg is the decoded digit idx from the capture register.
  - When cnt==SHOW_CYCLES-1 (SHOW_CYCLES = DIV-BLANK_CYCLES), the next edge goes to BLANK with idx advanced; idx wraps from 2 to 0.
- Frame capture:
  - A 12-bit capture register loads {centena,decena,unidad} on every edge while state==BLANK and idx==0.
  - Input changes at any other time do not affect the current frame; they appear in the next frame.
- Decode (active-low a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Codes 10–15 decode to 7'h7F (blank).
- seg and SevenSegmentEnable are registered; both change on the same edge as the state transition.

## Timing
- Reset values: seg=7'h7F, SevenSegmentEnable=3'b111, dot=1, state=BLANK, idx=0, cnt=0, capture=0.
- The first SHOW (idx 0) begins BLANK_CYCLES edges after the first edge with reset low.
- Slot period is exactly DIV cycles: BLANK_CYCLES off, then SHOW_CYCLES on. Frame period is 3·DIV cycles.
- Enables are never active for two digits in the same cycle, and never active during BLANK.
- Displayed digits equal the inputs sampled on the last BLANK cycle of idx 0.
- Reset asserted in any state forces all reset values on the next edge. A partial slot is abandoned.
- Divider widths use $clog2(DIV); no counter overflows at legal parameters.

## Configuration
- Macro: DISPLAY_SCAN_LZB_EN.
- When defined, leading-zero blanking applies:
  - centena is blanked when its captured value is 0.
  - decena is blanked when captured centena and decena are both 0.
  - unidad is never blanked.
  - A blanked digit keeps its slot timing, but its enable stays high (off) and seg=7'h7F.
- When undefined, all three digits are always shown, including zeros.

## Structure
- Package display_pkg holds:
  - SEG_BLANK constant
  - 10-entry segment ROM constant
  - enable pattern constants EN_CEN/EN_DEC/EN_UNI/EN_OFF
  - state enum {BLANK, SHOW}
- Sub-module bcd_seg_decode: combinational 4-bit to 7-bit decode using the package ROM. It is instantiated once on the muxed captured digit.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_HZ=100, BLANK_CYCLES=2, giving DIV=10 and SHOW_CYCLES=8.

1. Reset check: hold reset 3 cycles with inputs 0/3/2, then release.
   - Outputs are 7'h7F/3'b111/1 during reset.
   - Enables are 3'b111 for 2 cycles, then 3'b011 with seg=0000001 for 8 cycles.
   - Next: 2 blank cycles, 3'b101 with seg=0000110, 2 blank cycles, then 3'b110 with seg=0010010.
2. Frame consistency: change inputs from 0/3/2 to 0/1/5 during the decena slot.
   - The current frame still shows 3, 2.
   - The next frame shows 0, 1, 5.
3. Out-of-range digit: unidad=4'hC shows seg=7'h7F with enable 3'b110 asserted for 8 cycles.
4. Mid-slot reset: assert reset at cycle 4 of the decena SHOW.
   - The next edge gives 3'b111/7'h7F.
   - After release, scanning restarts at centena with a 2-cycle blank.
5. LZB on: with DISPLAY_SCAN_LZB_EN and inputs 0/0/7:
   - centena and decena slots keep enables 3'b111.
   - The unidad slot shows 0001111.
   - The frame period is still 30 cycles.
6. LZB off: with the same inputs and DISPLAY_SCAN_LZB_EN undefined, the display shows 0000001, 0000001, 0001111.
